corelet_sequencer: RTL and testbench

- Instruction sequencer directly upstream of the corelet/SRAM datapath.
- On start, it drives the 35-bit instruction word through every phase of a convolution layer:
  - weight fetch and load
  - activation fetch and execute
  - OFIFO drain to PMEM
  - PMEM accumulation with ReLU write-back
- It replaces testbench-driven instruction streams with a self-timed FSM that responds only to OFIFO valid.

---
 rtl/corelet_sequencer.sv | 251 +++++++++++++++++++++++++
 tb/tb_corelet_sequencer.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/corelet_sequencer.sv
// Self-timed instruction sequencer for one convolution layer: weight load, activation
// execute, OFIFO drain to PMEM, then PMEM accumulation with ReLU write-back.
module corelet_sequencer #(
    parameter int ROW        = 8,
    parameter int COL        = 8,
    parameter int LEN_NIJ    = 36,
    parameter int LEN_KIJ    = 9,
    parameter int FLUSH      = ROW + COL,
    parameter int W_BASE     = 1024,
    parameter int O_BASE     = 1024,
    parameter int INST_WIDTH = 35
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    input  logic                  ofifo_valid_i,
    output logic [INST_WIDTH-1:0] inst_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [3:0]            kij_idx_o
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_W_FETCH,
        S_W_LOAD,
        S_W_FLUSH,
        S_X_FETCH,
        S_X_EXEC,
        S_DRAIN,
        S_ACC,
        S_FIN
    } state_e;

    typedef struct packed {
        logic        sfp_relu;
        logic        sfp_acc;
        logic        cen_pmem;
        logic        wen_pmem;
        logic [10:0] a_pmem;
        logic        cen_xmem;
        logic        wen_xmem;
        logic [10:0] a_xmem;
        logic        ofifo_rd;
        logic [1:0]  rsvd;
        logic        l0_rd;
        logic        l0_wr;
        logic        execute;
        logic        load;
    } inst_t;

    localparam inst_t IDLE_WORD = '{
        sfp_relu: 1'b0, sfp_acc: 1'b0, cen_pmem: 1'b1, wen_pmem: 1'b1, a_pmem: 11'd0,
        cen_xmem: 1'b1, wen_xmem: 1'b1, a_xmem: 11'd0, ofifo_rd: 1'b0, rsvd: 2'b00,
        l0_rd: 1'b0, l0_wr: 1'b0, execute: 1'b0, load: 1'b0
    };

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    localparam int CW = $clog2(max4(COL + 1, FLUSH, LEN_NIJ + 1, LEN_KIJ + 3) + 1);
    localparam int NW = $clog2(LEN_NIJ + 1);
    localparam logic [10:0] W_BASE_A = 11'(W_BASE);
    localparam logic [10:0] O_BASE_A = 11'(O_BASE);

    state_e        state_q, state_d;
    logic [3:0]    kij_q, kij_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [NW-1:0] n_q, n_d;
    logic [NW-1:0] rd_cnt_q, rd_cnt_d;
    logic [NW-1:0] wr_cnt_q, wr_cnt_d;
    logic          pend_q, pend_d;
    inst_t         inst_q, inst_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    // NOTE: every output of this block is assigned a default before the case, so no
    // path through it can leave a signal unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        kij_d    = kij_q;
        cnt_d    = cnt_q;
        n_d      = n_q;
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        pend_d   = 1'b0;
        inst_d   = IDLE_WORD;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_W_FETCH;
                    kij_d   = '0;
                    cnt_d   = '0;
                end
            end
            S_W_FETCH: begin
                if (cnt_q < CW'(COL)) begin
                    inst_d.cen_xmem = 1'b0;
                    inst_d.a_xmem   = W_BASE_A + 11'(kij_q) * 11'(COL) + 11'(cnt_q);
                end
                // Read data lands one cycle after the read, so L0 writes lag by one.
                inst_d.l0_wr = (cnt_q != '0);
                if (cnt_q == CW'(COL)) begin
                    state_d = S_W_LOAD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_W_LOAD: begin
                inst_d.l0_rd = 1'b1;
                inst_d.load  = 1'b1;
                if (cnt_q == CW'(COL - 1)) begin
                    state_d = S_W_FLUSH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_W_FLUSH: begin
                if (cnt_q == CW'(FLUSH - 1)) begin
                    state_d = S_X_FETCH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_X_FETCH: begin
                if (cnt_q < CW'(LEN_NIJ)) begin
                    inst_d.cen_xmem = 1'b0;
                    inst_d.a_xmem   = 11'(cnt_q);
                end
                inst_d.l0_wr = (cnt_q != '0);
                if (cnt_q == CW'(LEN_NIJ)) begin
                    state_d = S_X_EXEC;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_X_EXEC: begin
                inst_d.l0_rd   = 1'b1;
                inst_d.execute = 1'b1;
                if (cnt_q == CW'(LEN_NIJ - 1)) begin
                    state_d  = S_DRAIN;
                    cnt_d    = '0;
                    rd_cnt_d = '0;
                    wr_cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DRAIN: begin
                if (ofifo_valid_i && (rd_cnt_q < NW'(LEN_NIJ))) begin
                    inst_d.ofifo_rd = 1'b1;
                    rd_cnt_d        = rd_cnt_q + NW'(1);
                    pend_d          = 1'b1;
                end
                // Writes retire in read order, so the write count is the row index.
                if (pend_q) begin
                    inst_d.cen_pmem = 1'b0;
                    inst_d.wen_pmem = 1'b0;
                    inst_d.a_pmem   = 11'(kij_q) * 11'(LEN_NIJ) + 11'(wr_cnt_q);
                    wr_cnt_d        = wr_cnt_q + NW'(1);
                    if (wr_cnt_q == NW'(LEN_NIJ - 1)) begin
                        cnt_d = '0;
                        n_d   = '0;
                        if (kij_q < 4'(LEN_KIJ - 1)) begin
                            kij_d   = kij_q + 4'd1;
                            state_d = S_W_FETCH;
                        end else begin
                            state_d = S_ACC;
                        end
                    end
                end
            end
            S_ACC: begin
                if (cnt_q < CW'(LEN_KIJ)) begin
                    inst_d.cen_pmem = 1'b0;
                    inst_d.a_pmem   = 11'(cnt_q) * 11'(LEN_NIJ) + 11'(n_q);
                end
                inst_d.sfp_acc  = (cnt_q != '0) && (cnt_q <= CW'(LEN_KIJ));
                inst_d.sfp_relu = (cnt_q == CW'(LEN_KIJ + 1));
                if (cnt_q == CW'(LEN_KIJ + 2)) begin
                    inst_d.cen_pmem = 1'b0;
                    inst_d.wen_pmem = 1'b0;
                    inst_d.a_pmem   = O_BASE_A + 11'(n_q);
                    cnt_d           = '0;
                    if (n_q == NW'(LEN_NIJ - 1)) begin
                        state_d = S_FIN;
                    end else begin
                        n_d = n_q + NW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // busy/done are registered with inst so all three stay cycle-aligned.
        busy_d = (state_d != S_IDLE);
        done_d = (state_q == S_FIN);
    end

    // NOTE: state updates use non-blocking assignments so every register samples
    // the pre-edge values; reset is synchronous and returns all state to IDLE.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= S_IDLE;
            kij_q    <= '0;
            cnt_q    <= '0;
            n_q      <= '0;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
            pend_q   <= 1'b0;
            inst_q   <= IDLE_WORD;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            kij_q    <= kij_d;
            cnt_q    <= cnt_d;
            n_q      <= n_d;
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
            pend_q   <= pend_d;
            inst_q   <= inst_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign inst_o    = inst_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign kij_idx_o = kij_q;

endmodule

// File: tb/tb_corelet_sequencer.sv
// Bench for corelet_sequencer: per-cycle expected instruction words are queued from
// spec-shaped phase loops, then replayed against the DUT one clock at a time.
`timescale 1ns/1ps
module tb_corelet_sequencer;

    localparam int COL     = 8;
    localparam int LEN_NIJ = 36;
    localparam int LEN_KIJ = 9;
    localparam int FLUSH   = 16;
    localparam int W_BASE  = 1024;
    localparam int O_BASE  = 1024;

    typedef struct packed {
        logic        sfp_relu;
        logic        sfp_acc;
        logic        cen_pmem;
        logic        wen_pmem;
        logic [10:0] a_pmem;
        logic        cen_xmem;
        logic        wen_xmem;
        logic [10:0] a_xmem;
        logic        ofifo_rd;
        logic [1:0]  rsvd;
        logic        l0_rd;
        logic        l0_wr;
        logic        execute;
        logic        load;
    } inst_t;

    localparam inst_t IDLE_WORD = 35'h1_800C_0000;

    // One cycle of stimulus plus the outputs expected right after that cycle's edge.
    typedef struct {
        inst_t word;
        logic  start;
        logic  valid;
        logic  rst;
        logic  busy;
        logic  done;
        int    kij;
    } cyc_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        ofifo_valid = 1'b0;
    logic [34:0] inst;
    logic        busy;
    logic        done;
    logic [3:0]  kij_idx;

    cyc_t sb[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   rd_seen, wr_seen, xr_seen, done_seen;

    corelet_sequencer dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .start_i       (start),
        .ofifo_valid_i (ofifo_valid),
        .inst_o        (inst),
        .busy_o        (busy),
        .done_o        (done),
        .kij_idx_o     (kij_idx)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic cyc_t blank();
        cyc_t e;
        e.word  = IDLE_WORD;
        e.start = 1'b0;
        e.valid = 1'b0;
        e.rst   = 1'b0;
        e.busy  = 1'b0;
        e.done  = 1'b0;
        e.kij   = -1;
        return e;
    endfunction

    task automatic push_reset();
        cyc_t e;
        e = blank();
        e.rst = 1'b1;
        e.kij = 0;
        sb.push_back(e);
    endtask

    // Queue a full layer; optionally abort with reset after the weight phase
    // (abort_in_weight) or 10 cycles into X_EXEC of kij == abort_kij.
    task automatic gen_layer(input bit toggle, input int abort_kij,
                             input bit abort_in_weight, input bit acc_start);
        cyc_t e;
        int   dl;
        e = blank(); e.start = 1'b1; e.busy = 1'b1; e.kij = 0;
        sb.push_back(e);
        for (int k = 0; k < LEN_KIJ; k++) begin
            for (int c = 0; c <= COL; c++) begin
                e = blank(); e.busy = 1'b1; e.kij = k;
                if (c < COL) begin
                    e.word.cen_xmem = 1'b0;
                    e.word.a_xmem   = 11'(W_BASE + k * COL + c);
                end
                if (c >= 1) e.word.l0_wr = 1'b1;
                sb.push_back(e);
            end
            for (int c = 0; c < COL; c++) begin
                e = blank(); e.busy = 1'b1; e.kij = k;
                e.word.l0_rd = 1'b1;
                e.word.load  = 1'b1;
                sb.push_back(e);
            end
            for (int c = 0; c < FLUSH; c++) begin
                e = blank(); e.busy = 1'b1; e.kij = k;
                sb.push_back(e);
            end
            if (abort_in_weight && k == abort_kij) begin
                push_reset();
                return;
            end
            for (int c = 0; c <= LEN_NIJ; c++) begin
                e = blank(); e.busy = 1'b1; e.kij = k;
                if (c < LEN_NIJ) begin
                    e.word.cen_xmem = 1'b0;
                    e.word.a_xmem   = 11'(c);
                end
                if (c >= 1) e.word.l0_wr = 1'b1;
                sb.push_back(e);
            end
            for (int c = 0; c < LEN_NIJ; c++) begin
                if (!abort_in_weight && k == abort_kij && c == 10) begin
                    push_reset();
                    return;
                end
                e = blank(); e.busy = 1'b1; e.kij = k;
                e.word.l0_rd   = 1'b1;
                e.word.execute = 1'b1;
                sb.push_back(e);
            end
            // Valid tied high: reads on 0..35, writes on 1..36. Toggling: reads on even
            // cycles, each write on the following odd cycle.
            dl = toggle ? 2 * LEN_NIJ : LEN_NIJ + 1;
            for (int d = 0; d < dl; d++) begin
                e = blank(); e.busy = 1'b1;
                e.kij = (d == dl - 1 && k < LEN_KIJ - 1) ? k + 1 : k;
                if (toggle) begin
                    e.valid = (d % 2 == 0);
                    if (d % 2 == 0) begin
                        e.word.ofifo_rd = 1'b1;
                    end else begin
                        e.word.cen_pmem = 1'b0;
                        e.word.wen_pmem = 1'b0;
                        e.word.a_pmem   = 11'(k * LEN_NIJ + (d - 1) / 2);
                    end
                end else begin
                    e.valid = 1'b1;
                    if (d < LEN_NIJ) e.word.ofifo_rd = 1'b1;
                    if (d >= 1) begin
                        e.word.cen_pmem = 1'b0;
                        e.word.wen_pmem = 1'b0;
                        e.word.a_pmem   = 11'(k * LEN_NIJ + d - 1);
                    end
                end
                sb.push_back(e);
            end
        end
        for (int n = 0; n < LEN_NIJ; n++) begin
            for (int g = 0; g < LEN_KIJ + 3; g++) begin
                e = blank(); e.busy = 1'b1; e.kij = LEN_KIJ - 1;
                e.start = acc_start && (n == 3) && (g == 4);
                if (g < LEN_KIJ) begin
                    e.word.cen_pmem = 1'b0;
                    e.word.a_pmem   = 11'(g * LEN_NIJ + n);
                end
                if (g >= 1 && g <= LEN_KIJ) e.word.sfp_acc = 1'b1;
                if (g == LEN_KIJ + 1) e.word.sfp_relu = 1'b1;
                if (g == LEN_KIJ + 2) begin
                    e.word.cen_pmem = 1'b0;
                    e.word.wen_pmem = 1'b0;
                    e.word.a_pmem   = 11'(O_BASE + n);
                end
                sb.push_back(e);
            end
        end
        e = blank(); e.done = 1'b1;
        sb.push_back(e);
        e = blank();
        sb.push_back(e);
    endtask

    // Scoreboard consumer: drive each queued cycle, clock it, compare the result.
    task automatic play(input string tag);
        cyc_t e;
        int   idx;
        idx = 0;
        rd_seen = 0; wr_seen = 0; xr_seen = 0; done_seen = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            reset       = e.rst;
            start       = e.start;
            ofifo_valid = e.valid;
            @(posedge clk);
            #1;
            n_checks++;
            if (inst !== e.word)
                $display("FAIL %s inst cyc %0d: got %h exp %h", tag, idx, inst, e.word);
            else n_pass++;
            n_checks++;
            if (busy !== e.busy || done !== e.done)
                $display("FAIL %s busy/done cyc %0d: got %b/%b exp %b/%b",
                         tag, idx, busy, done, e.busy, e.done);
            else n_pass++;
            if (e.kij >= 0) begin
                n_checks++;
                if (kij_idx !== 4'(e.kij))
                    $display("FAIL %s kij_idx cyc %0d: got %0d exp %0d", tag, idx, kij_idx, e.kij);
                else n_pass++;
            end
            if (inst[6] === 1'b1) rd_seen++;
            if (inst[32] === 1'b0 && inst[31] === 1'b0) wr_seen++;
            if (inst[19] === 1'b0 && inst[18] === 1'b1) xr_seen++;
            if (done === 1'b1) done_seen++;
            idx++;
        end
        reset = 1'b0; start = 1'b0; ofifo_valid = 1'b0;
    endtask

    task automatic test_reset();
        cyc_t e;
        reset = 1'b1; start = 1'b0; ofifo_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        push_reset();
        for (int i = 0; i < 20; i++) begin
            e = blank(); e.kij = 0;
            sb.push_back(e);
        end
        play("reset");
        n_checks++;
        if (inst !== 35'h1_800C_0000 || busy !== 1'b0)
            $display("FAIL reset_hold: got inst %h busy %b exp 1800c0000 0", inst, busy);
        else n_pass++;
    endtask

    task automatic test_weight_phase();
        gen_layer(1'b0, 0, 1'b1, 1'b0);
        play("weight");
        n_checks++;
        if (xr_seen !== 8) $display("FAIL weight xmem_reads: got %0d exp 8", xr_seen);
        else n_pass++;
        n_checks++;
        if (rd_seen !== 0 || wr_seen !== 0)
            $display("FAIL weight stray_ops: got rd %0d wr %0d exp 0 0", rd_seen, wr_seen);
        else n_pass++;
    endtask

    task automatic test_full_layer();
        gen_layer(1'b0, -1, 1'b0, 1'b0);
        play("full");
        n_checks++;
        if (rd_seen !== LEN_KIJ * LEN_NIJ)
            $display("FAIL full ofifo_rd_count: got %0d exp %0d", rd_seen, LEN_KIJ * LEN_NIJ);
        else n_pass++;
        n_checks++;
        if (wr_seen !== (LEN_KIJ + 1) * LEN_NIJ)
            $display("FAIL full pmem_writes: got %0d exp %0d", wr_seen, (LEN_KIJ + 1) * LEN_NIJ);
        else n_pass++;
        n_checks++;
        if (xr_seen !== LEN_KIJ * (COL + LEN_NIJ))
            $display("FAIL full xmem_reads: got %0d exp %0d", xr_seen, LEN_KIJ * (COL + LEN_NIJ));
        else n_pass++;
        n_checks++;
        if (done_seen !== 1) $display("FAIL full done_pulses: got %0d exp 1", done_seen);
        else n_pass++;
    endtask

    task automatic test_drain_stalls();
        gen_layer(1'b1, -1, 1'b0, 1'b0);
        play("stall");
        n_checks++;
        if (rd_seen !== LEN_KIJ * LEN_NIJ)
            $display("FAIL stall ofifo_rd_count: got %0d exp %0d", rd_seen, LEN_KIJ * LEN_NIJ);
        else n_pass++;
        n_checks++;
        if (wr_seen !== (LEN_KIJ + 1) * LEN_NIJ)
            $display("FAIL stall pmem_writes: got %0d exp %0d", wr_seen, (LEN_KIJ + 1) * LEN_NIJ);
        else n_pass++;
        n_checks++;
        if (done_seen !== 1) $display("FAIL stall done_pulses: got %0d exp 1", done_seen);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        gen_layer(1'b0, 4, 1'b0, 1'b0);
        play("reset_mid");
        n_checks++;
        if (inst !== 35'h1_800C_0000 || busy !== 1'b0 || kij_idx !== 4'd0)
            $display("FAIL reset_mid state: got inst %h busy %b kij %0d exp 1800c0000 0 0",
                     inst, busy, kij_idx);
        else n_pass++;
        gen_layer(1'b0, -1, 1'b0, 1'b0);
        play("restart");
        n_checks++;
        if (done_seen !== 1) $display("FAIL restart done_pulses: got %0d exp 1", done_seen);
        else n_pass++;
    endtask

    task automatic test_start_while_busy();
        gen_layer(1'b0, -1, 1'b0, 1'b1);
        play("start_busy");
        n_checks++;
        if (done_seen !== 1) $display("FAIL start_busy done_pulses: got %0d exp 1", done_seen);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_weight_phase();
        test_full_layer();
        test_drain_stalls();
        test_reset_mid();
        test_start_while_busy();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
